// File: rtl/contador_pkg.sv
// Shared constants and helpers for the hex counter / digit scan slice.
// Holds the nibble width and the active-low one-hot digit encoding.
package contador_pkg;

  localparam int DIG_W = 4;

  // Active-low one-hot, masked to n digits.
  function automatic logic [31:0] onehot_low(
    input int unsigned idx,
    input int unsigned n
  );
    logic [31:0] m;
    m = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return ~(32'd1 << idx) & m;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Modulo-DIV counter with enable and synchronous restart.
// Emits a one-cycle terminal pulse when enabled at DIV-1.
module divisor_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic pulse
);

  localparam int W = $clog2(DIV) + 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign pulse = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || pulse) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/contador_hex_mux.sv
// Prescaled hex up/down counter with time-multiplexed digit scan.
// Feeds one nibble per cycle to a 7-segment decoder plus its anode.
module contador_hex_mux
  import contador_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESC    = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [DIG_W*NDIG-1:0] load_val,
  input  logic                  clr,
  output logic [DIG_W*NDIG-1:0] count,
  output logic                  tick,
  output logic                  wrap,
  output logic [DIG_W-1:0]      bin,
  output logic [NDIG-1:0]       an
);

  localparam int CW = DIG_W * NDIG;
  localparam int IW = $clog2(NDIG) + 1;
  localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);

  logic          step;
  logic          scan_adv;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;

  divisor_tick #(
    .DIV(PRESC)
  ) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (clr | load),
    .pulse   (step)
  );

  divisor_tick #(
    .DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .restart (1'b0),
    .pulse   (scan_adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (step) begin
        tick <= 1'b1;
        if (up_dn) begin
          count <= count + CW'(1);
          wrap  <= (count == '1);
        end else begin
          count <= count - CW'(1);
          wrap  <= (count == '0);
        end
      end
    end
  end

  assign idx_nxt = (idx == ILAST) ? '0 : idx + IW'(1);

  // an is loaded with idx so both change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      an  <= NDIG'(onehot_low(32'd0, NDIG));
    end else if (scan_adv) begin
      idx <= idx_nxt;
      an  <= NDIG'(onehot_low(32'(idx_nxt), NDIG));
    end
  end

  always_comb begin
    bin = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        bin = count[i*DIG_W +: DIG_W];
      end
    end
  end

endmodule

// File: tb/tb_contador_hex_mux.sv
// Directed bench for contador_hex_mux with NDIG=4, PRESC=4, SCAN_DIV=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_contador_hex_mux;

  localparam int NDIG     = 4;
  localparam int PRESC    = 4;
  localparam int SCAN_DIV = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic        clr;
  logic [15:0] count;
  logic        tick;
  logic        wrap;
  logic [3:0]  bin;
  logic [3:0]  an;

  int checks;
  int errors;

  contador_hex_mux #(
    .NDIG    (NDIG),
    .PRESC   (PRESC),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .clr     (clr),
    .count   (count),
    .tick    (tick),
    .wrap    (wrap),
    .bin     (bin),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    en = 1'b1;
    up_dn = 1'b1;
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_count got %h exp 0000", count);
    end
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL reset_an got %b exp 1110", an);
    end
    checks++;
    if (bin !== 4'h0) begin
      errors++;
      $display("FAIL reset_bin got %h exp 0", bin);
    end
    checks++;
    if (tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_tw got %b%b exp 00", tick, wrap);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up;
    int nt;
    logic prev;
    nt = 0;
    prev = 1'b0;
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick) nt++;
      checks++;
      if (tick && prev) begin
        errors++;
        $display("FAIL up_tick_width got 2-cycle tick at %0d exp 1", i);
      end
      prev = tick;
    end
    checks++;
    if (count !== 16'h0004) begin
      errors++;
      $display("FAIL up_count got %h exp 0004", count);
    end
    checks++;
    if (nt != 4) begin
      errors++;
      $display("FAIL up_ticks got %0d exp 4", nt);
    end
  endtask

  task automatic test_en_gap;
    int nt;
    nt = 0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    checks++;
    if (count !== 16'h0004 || nt != 0) begin
      errors++;
      $display("FAIL gap_frozen got %h/%0d exp 0004/0", count, nt);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 16'h0004) begin
      errors++;
      $display("FAIL gap_pc1 got %h exp 0004", count);
    end
    @(negedge clk);
    checks++;
    if (count !== 16'h0005 || tick !== 1'b1) begin
      errors++;
      $display("FAIL gap_pc2 got %h/%b exp 0005/1", count, tick);
    end
  endtask

  task automatic test_wrap_up;
    int nw;
    nw = 0;
    en = 1'b0;
    load = 1'b1;
    load_val = 16'hFFFE;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (count !== 16'hFFFE || tick !== 1'b0) begin
      errors++;
      $display("FAIL wup_load got %h/%b exp FFFE/0", count, tick);
    end
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (wrap) nw++;
      if (i == 4) begin
        checks++;
        if (count !== 16'hFFFF || wrap !== 1'b0) begin
          errors++;
          $display("FAIL wup_ffff got %h/%b exp FFFF/0", count, wrap);
        end
      end
    end
    checks++;
    if (count !== 16'h0000 || wrap !== 1'b1 || tick !== 1'b1) begin
      errors++;
      $display("FAIL wup_0000 got %h/%b%b exp 0000/11",
               count, wrap, tick);
    end
    checks++;
    if (nw != 1) begin
      errors++;
      $display("FAIL wup_count got %0d exp 1", nw);
    end
  endtask

  task automatic test_wrap_down;
    int nw;
    nw = 0;
    up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wrap) nw++;
    end
    checks++;
    if (count !== 16'hFFFF || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wdn_ffff got %h/%b exp FFFF/1", count, wrap);
    end
    checks++;
    if (nw != 1) begin
      errors++;
      $display("FAIL wdn_count got %0d exp 1", nw);
    end
  endtask

  task automatic test_priority;
    en = 1'b0;
    clr = 1'b1;
    load = 1'b1;
    load_val = 16'h1234;
    @(negedge clk);
    clr = 1'b0;
    load = 1'b0;
    checks++;
    if (count !== 16'h0000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL pri_clr got %h/%b exp 0000/0", count, tick);
    end
    en = 1'b1;
    up_dn = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b1;
    load_val = 16'hABCD;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (count !== 16'hABCD || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL pri_load got %h/%b%b exp ABCD/00",
               count, tick, wrap);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (count !== 16'hABCD || tick !== 1'b0) begin
      errors++;
      $display("FAIL pri_pc_rst got %h/%b exp ABCD/0", count, tick);
    end
    @(negedge clk);
    checks++;
    if (count !== 16'hABCE || tick !== 1'b1) begin
      errors++;
      $display("FAIL pri_step got %h/%b exp ABCE/1", count, tick);
    end
  endtask

  task automatic test_scan;
    logic [3:0] prev;
    logic [3:0] exp_an [4];
    logic [3:0] exp_bin [4];
    bit found;
    exp_an[0] = 4'b1110;
    exp_an[1] = 4'b1101;
    exp_an[2] = 4'b1011;
    exp_an[3] = 4'b0111;
    exp_bin[0] = 4'h4;
    exp_bin[1] = 4'h3;
    exp_bin[2] = 4'h2;
    exp_bin[3] = 4'h1;
    en = 1'b0;
    load = 1'b1;
    load_val = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = an;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_sync got no 1110 entry exp within 20 clk");
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        checks++;
        if (an !== exp_an[k/2] || bin !== exp_bin[k/2]) begin
          errors++;
          $display("FAIL scan_%0d got %b/%h exp %b/%h",
                   k, an, bin, exp_an[k/2], exp_bin[k/2]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = 1'b0;
    up_dn = 1'b1;
    load = 1'b0;
    load_val = '0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_count_up();
    test_en_gap();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
